// File: rtl/multdiv_pkg.sv
// ----------------------------------------------------------------------------
// multdiv_pkg
// Shared types and constants for the iterative multiply/divide unit.
//   md_state_e  : control FSM states (IDLE, MUL, DIV, DONE)
//   MD_ITERS    : iterations per operation (one result bit per cycle)
//   MD_INT_MIN  : most negative 32-bit value, the only divide-overflow dividend
// ----------------------------------------------------------------------------
package multdiv_pkg;

   typedef enum logic [1:0] {
      IDLE,
      MUL,
      DIV,
      DONE
   } md_state_e;

   localparam int          MD_ITERS   = 32;
   localparam logic [31:0] MD_INT_MIN = 32'h8000_0000;

endpackage

// File: rtl/multdiv_unit_addsub32.sv
// ----------------------------------------------------------------------------
// addsub32
// Combinational 32-bit adder/subtractor shared by the Booth step, the
// restoring trial subtract and the final quotient negation.
// Ports:
//   a, b      in  32  operands
//   sub       in  1   0: a + b, 1: a - b (b inverted, carry-in 1)
//   sum       out 32  result
//   carry_out out 1   carry out of bit 31 (1 = no borrow when subtracting)
// ----------------------------------------------------------------------------
module addsub32 (
   input  logic [31:0] a,
   input  logic [31:0] b,
   input  logic        sub,
   output logic [31:0] sum,
   output logic        carry_out
);

   logic [31:0] b_eff;

   assign b_eff            = sub ? ~b : b;
   assign {carry_out, sum} = {1'b0, a} + {1'b0, b_eff} + {32'd0, sub};

endmodule

// File: rtl/multdiv_unit.sv
// ----------------------------------------------------------------------------
// multdiv_unit
// Multi-cycle signed 32-bit multiplier (radix-2 Booth, low word of product)
// and divider (restoring on magnitudes, quotient truncated toward zero).
// 32 iterations plus one fix-up cycle; a one-cycle RDY pulse reports the
// result, which is held until the next completion.
// Ports:
//   clock           in  1   rising-edge clock
//   reset_n         in  1   synchronous active-low reset
//   data_operandA   in  32  multiplicand / dividend (signed)
//   data_operandB   in  32  multiplier / divisor (signed)
//   ctrl_MULT       in  1   start a multiply
//   ctrl_DIV        in  1   start a divide
//   data_result     out 32  result, held until next completion
//   data_exception  out 1   overflow / divide-by-zero flag
//   data_resultRDY  out 1   one-cycle completion pulse
//   busy            out 1   high while iterating
// Configuration:
//   MULTDIV_DIV_EN  defined: divider present. Undefined: every divide
//                   completes one cycle after its start with result 0 and
//                   exception 1.
// ----------------------------------------------------------------------------
module multdiv_unit
   import multdiv_pkg::*;
(
   input  logic        clock,
   input  logic        reset_n,
   input  logic [31:0] data_operandA,
   input  logic [31:0] data_operandB,
   input  logic        ctrl_MULT,
   input  logic        ctrl_DIV,
   output logic [31:0] data_result,
   output logic        data_exception,
   output logic        data_resultRDY,
   output logic        busy
);

   md_state_e   state, state_next;
   logic [4:0]  cnt;
   logic        fixup;      // all iterations done, next edge writes the result
   logic        err_pend;   // rejected start, report it on the following edge
   logic [31:0] acc;        // Booth accumulator / division remainder
   logic [31:0] mq;         // multiplier -> product low / dividend -> quotient
   logic [31:0] m_reg;      // multiplicand / divisor magnitude
   logic        q_m1;       // Booth q(-1) bit
`ifdef MULTDIV_DIV_EN
   logic        neg;
   logic        div_zero;
   logic        div_ovf;
`endif

   logic        start, start_err;
   logic [31:0] add_a, add_b, add_sum;
   logic        add_sub, add_cout;
   logic [32:0] booth_acc;
   logic [31:0] nxt_acc, nxt_mq, fix_result;
   logic        nxt_qm1, fix_exc;

   assign start = ctrl_MULT | ctrl_DIV;
`ifdef MULTDIV_DIV_EN
   assign start_err = ctrl_MULT & ctrl_DIV;
`else
   assign start_err = ctrl_DIV;   // covers both-high as well
`endif

   // ---------------------------------------------------------------- FSM
   // NOTE: sequential state uses non-blocking (<=) so every register samples
   // the pre-edge value of every other register, independent of block order.
   always_ff @(posedge clock) begin
      if (!reset_n) state <= IDLE;
      else          state <= state_next;
   end

   // NOTE: every output of a combinational block gets a default first, so no
   // path leaves it unassigned and no latch is inferred.
   always_comb begin
      state_next = state;
      if (start_err)      state_next = IDLE;
      else if (ctrl_MULT) state_next = MUL;
`ifdef MULTDIV_DIV_EN
      else if (ctrl_DIV)  state_next = DIV;
`endif
      else if (err_pend)  state_next = DONE;
      else begin
         unique case (state)
            MUL, DIV: if (fixup) state_next = DONE;
            DONE:     state_next = IDLE;
            default:  state_next = state;
         endcase
      end
      busy           = (state == MUL) || (state == DIV);
      data_resultRDY = (state == DONE);
   end

   // ---------------------------------------------------------- shared adder
   always_comb begin
      add_a   = acc;
      add_b   = m_reg;
      add_sub = mq[0];               // Booth pair 10 subtracts, 01 adds
`ifdef MULTDIV_DIV_EN
      if (state == DIV) begin
         add_sub = 1'b1;
         if (fixup) begin
            add_a = '0;                // negate the quotient magnitude
            add_b = mq;
         end else begin
            add_a = {acc[30:0], mq[31]};  // shifted partial remainder
         end
      end
`endif
   end

   addsub32 u_addsub (
      .a         (add_a),
      .b         (add_b),
      .sub       (add_sub),
      .sum       (add_sum),
      .carry_out (add_cout)
   );

   // ------------------------------------------------------ next-step values
   always_comb begin
      // Booth: the 33rd sum bit is rebuilt from the carry so an add/sub that
      // overflows 32 bits (e.g. 0 - INT_MIN) still shifts in the true sign.
      booth_acc = (mq[0] ^ q_m1)
                ? {acc[31] ^ m_reg[31] ^ add_sub ^ add_cout, add_sum}
                : {acc[31], acc};
      nxt_acc    = booth_acc[32:1];
      nxt_mq     = {booth_acc[0], mq[31:1]};
      nxt_qm1    = mq[0];
      fix_result = mq;
      fix_exc    = (acc != {32{mq[31]}});   // product[63:31] not all-equal
`ifdef MULTDIV_DIV_EN
      if (state == DIV) begin
         // carry out of the trial subtract means remainder >= divisor
         nxt_acc    = add_cout ? add_sum : add_a;
         nxt_mq     = {mq[30:0], add_cout};
         nxt_qm1    = 1'b0;
         fix_result = div_zero ? '0 : (neg ? add_sum : mq);
         fix_exc    = div_zero | div_ovf;
      end
`endif
   end

   // -------------------------------------------------------------- datapath
   always_ff @(posedge clock) begin
      if (!reset_n) begin
         cnt            <= '0;
         fixup          <= 1'b0;
         err_pend       <= 1'b0;
         acc            <= '0;
         mq             <= '0;
         m_reg          <= '0;
         q_m1           <= 1'b0;
         data_result    <= '0;
         data_exception <= 1'b0;
`ifdef MULTDIV_DIV_EN
         neg            <= 1'b0;
         div_zero       <= 1'b0;
         div_ovf        <= 1'b0;
`endif
      end else begin
         err_pend <= 1'b0;
         if (start) begin
            cnt   <= '0;
            fixup <= 1'b0;
            acc   <= '0;
            q_m1  <= 1'b0;
            if (start_err) begin
               err_pend <= 1'b1;
            end else if (ctrl_MULT) begin
               m_reg <= data_operandA;
               mq    <= data_operandB;
            end
`ifdef MULTDIV_DIV_EN
            else begin
               m_reg    <= data_operandB[31] ? -data_operandB : data_operandB;
               mq       <= data_operandA[31] ? -data_operandA : data_operandA;
               neg      <= data_operandA[31] ^ data_operandB[31];
               div_zero <= (data_operandB == '0);
               div_ovf  <= (data_operandA == MD_INT_MIN) && (data_operandB == '1);
            end
`endif
         end else if (err_pend) begin
            data_result    <= '0;
            data_exception <= 1'b1;
         end else if (busy) begin
            if (!fixup) begin
               acc  <= nxt_acc;
               mq   <= nxt_mq;
               q_m1 <= nxt_qm1;
               cnt  <= cnt + 5'd1;
               if (cnt == 5'(MD_ITERS - 1)) fixup <= 1'b1;
            end else begin
               data_result    <= fix_result;
               data_exception <= fix_exc;
               fixup          <= 1'b0;
            end
         end
      end
   end

endmodule

// File: tb/tb_multdiv_unit.sv
// ----------------------------------------------------------------------------
// tb_multdiv_unit
// Self-checking bench for multdiv_unit: a table of directed multiply/divide
// vectors with hand-computed results and latencies, followed by hand-written
// sequences for restart, back-to-back issue and mid-operation reset.
// Divide vectors follow MULTDIV_DIV_EN in the same way as the design.
// ----------------------------------------------------------------------------
module tb_multdiv_unit;

   logic        clock = 1'b0;
   logic        reset_n;
   logic [31:0] data_operandA, data_operandB;
   logic        ctrl_MULT, ctrl_DIV;
   logic [31:0] data_result;
   logic        data_exception, data_resultRDY, busy;

   int          n_checks = 0;
   int          n_pass   = 0;
   logic [31:0] last_res = '0;
   logic        last_exc = 1'b0;

   typedef struct {
      logic [31:0] a;
      logic [31:0] b;
      logic        mul;
      logic        div;
      logic [31:0] res;
      logic        exc;
      int          lat;
   } vec_t;

   vec_t vecs[$];

   always #5 clock = ~clock;

   multdiv_unit dut (
      .clock          (clock),
      .reset_n        (reset_n),
      .data_operandA  (data_operandA),
      .data_operandB  (data_operandB),
      .ctrl_MULT      (ctrl_MULT),
      .ctrl_DIV       (ctrl_DIV),
      .data_result    (data_result),
      .data_exception (data_exception),
      .data_resultRDY (data_resultRDY),
      .busy           (busy)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h, expected %h", name, act, exp);
   endtask

   task automatic start_op(input logic [31:0] a, input logic [31:0] b,
                           input logic m, input logic d);
      @(negedge clock);
      data_operandA = a;
      data_operandB = b;
      ctrl_MULT     = m;
      ctrl_DIV      = d;
      @(posedge clock);
      #1;
      ctrl_MULT     = 1'b0;
      ctrl_DIV      = 1'b0;
      data_operandA = $urandom;
      data_operandB = $urandom;
   endtask

   // Called 1 time unit after the start edge; returns edges until RDY.
   task automatic wait_rdy(input logic exp_busy, output int lat,
                           output int bad_busy, output int bad_hold);
      lat = 0; bad_busy = 0; bad_hold = 0;
      forever begin
         if (busy !== exp_busy) bad_busy++;
         if (data_result !== last_res || data_exception !== last_exc) bad_hold++;
         @(posedge clock);
         #1;
         lat++;
         if (data_resultRDY === 1'b1 || lat >= 100) break;
      end
      if (busy !== 1'b0) bad_busy++;
   endtask

   task automatic check_done(input string tag, input int lat, input int bb, input int bh,
                             input logic [31:0] exp_res, input logic exp_exc, input int exp_lat);
      check({tag, " latency"},  32'(lat), 32'(exp_lat));
      check({tag, " result"},   data_result, exp_res);
      check({tag, " exception"}, {31'd0, data_exception}, {31'd0, exp_exc});
      check({tag, " busy"},     32'(bb), 32'd0);
      check({tag, " hold"},     32'(bh), 32'd0);
      last_res = exp_res;
      last_exc = exp_exc;
   endtask

   task automatic run_op(input string tag, input vec_t v);
      int lat, bb, bh;
      start_op(v.a, v.b, v.mul, v.div);
      wait_rdy(v.lat > 1, lat, bb, bh);
      check_done(tag, lat, bb, bh, v.res, v.exc, v.lat);
      @(posedge clock);
      #1;
      check({tag, " rdy fall"}, {31'd0, data_resultRDY}, 32'd0);
   endtask

   initial begin
      int lat, bb, bh, rdy_seen;
      logic [31:0] r2_a, r2_b, r2_res;
      logic        r2_mul, r2_div;

      //        a             b             mul   div   res           exc   lat
      vecs.push_back('{32'd7,        32'hFFFFFFFD, 1'b1, 1'b0, 32'hFFFFFFEB, 1'b0, 33});
      vecs.push_back('{32'h00010000, 32'h00010000, 1'b1, 1'b0, 32'h00000000, 1'b1, 33});
      vecs.push_back('{32'h80000000, 32'd1,        1'b1, 1'b0, 32'h80000000, 1'b0, 33});
      vecs.push_back('{32'h80000000, 32'hFFFFFFFF, 1'b1, 1'b0, 32'h80000000, 1'b1, 33});
      vecs.push_back('{32'h80000000, 32'h80000000, 1'b1, 1'b0, 32'h00000000, 1'b1, 33});
      vecs.push_back('{32'h7FFFFFFF, 32'h7FFFFFFF, 1'b1, 1'b0, 32'h00000001, 1'b1, 33});
      vecs.push_back('{32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 1'b0, 32'h00000001, 1'b0, 33});
      vecs.push_back('{32'd12345,    32'hFFFFE57B, 1'b1, 1'b0, 32'hFB012863, 1'b0, 33});
      vecs.push_back('{32'h0000FFFF, 32'h00010001, 1'b1, 1'b0, 32'hFFFFFFFF, 1'b1, 33});
      vecs.push_back('{32'hFFFF0000, 32'h00008000, 1'b1, 1'b0, 32'h80000000, 1'b0, 33});
      vecs.push_back('{32'd0,        32'hDEADBEEF, 1'b1, 1'b0, 32'h00000000, 1'b0, 33});
      vecs.push_back('{32'd9,        32'd9,        1'b1, 1'b1, 32'h00000000, 1'b1, 1});
`ifdef MULTDIV_DIV_EN
      vecs.push_back('{32'hFFFFFFF9, 32'd2,        1'b0, 1'b1, 32'hFFFFFFFD, 1'b0, 33});
      vecs.push_back('{32'd100,      32'd7,        1'b0, 1'b1, 32'd14,       1'b0, 33});
      vecs.push_back('{32'hFFFFFF9C, 32'hFFFFFFF9, 1'b0, 1'b1, 32'd14,       1'b0, 33});
      vecs.push_back('{32'd5,        32'd0,        1'b0, 1'b1, 32'h00000000, 1'b1, 33});
      vecs.push_back('{32'h80000000, 32'hFFFFFFFF, 1'b0, 1'b1, 32'h80000000, 1'b1, 33});
      vecs.push_back('{32'h80000000, 32'd1,        1'b0, 1'b1, 32'h80000000, 1'b0, 33});
      vecs.push_back('{32'h7FFFFFFF, 32'h80000000, 1'b0, 1'b1, 32'h00000000, 1'b0, 33});
      vecs.push_back('{32'd3,        32'd5,        1'b0, 1'b1, 32'h00000000, 1'b0, 33});
      r2_a = 32'd100; r2_b = 32'd7; r2_mul = 1'b0; r2_div = 1'b1; r2_res = 32'd14;
`else
      vecs.push_back('{32'd100,      32'd7,        1'b0, 1'b1, 32'h00000000, 1'b1, 1});
      vecs.push_back('{32'd5,        32'd0,        1'b0, 1'b1, 32'h00000000, 1'b1, 1});
      r2_a = 32'd5; r2_b = 32'd6; r2_mul = 1'b1; r2_div = 1'b0; r2_res = 32'd30;
`endif

      // reset state
      reset_n = 1'b0; ctrl_MULT = 1'b0; ctrl_DIV = 1'b0;
      data_operandA = '0; data_operandB = '0;
      repeat (3) @(posedge clock);
      #1;
      check("reset result", data_result, 32'd0);
      check("reset flags", {29'd0, data_exception, data_resultRDY, busy}, 32'd0);
      @(negedge clock);
      reset_n = 1'b1;

      for (int i = 0; i < vecs.size(); i++)
         run_op($sformatf("vec%0d", i), vecs[i]);

      // restart: second start at cycle 10 aborts the first, one RDY only
      start_op(32'd3, 32'd4, 1'b1, 1'b0);
      repeat (9) @(posedge clock);
      start_op(r2_a, r2_b, r2_mul, r2_div);
      wait_rdy(1'b1, lat, bb, bh);
      check_done("restart", lat, bb, bh, r2_res, 1'b0, 33);

      // back-to-back: new MULT issued during the DONE cycle
      start_op(32'd2, 32'd2, 1'b1, 1'b0);
      wait_rdy(1'b1, lat, bb, bh);
      check_done("b2b", lat, bb, bh, 32'd4, 1'b0, 33);

      // reset at cycle 20 of a multiply
      start_op(32'h00010000, 32'h00010000, 1'b1, 1'b0);
      repeat (19) @(posedge clock);
      @(negedge clock);
      reset_n = 1'b0;
      @(posedge clock);
      #1;
      check("midreset result", data_result, 32'd0);
      check("midreset flags", {29'd0, data_exception, data_resultRDY, busy}, 32'd0);
      @(negedge clock);
      reset_n = 1'b1;
      last_res = '0;
      last_exc = 1'b0;
      rdy_seen = 0;
      repeat (40) begin
         @(posedge clock);
         #1;
         if (data_resultRDY === 1'b1 || busy !== 1'b0) rdy_seen++;
      end
      check("midreset no rdy", 32'(rdy_seen), 32'd0);

      // both controls high after reset
      run_op("both", '{32'd1, 32'd1, 1'b1, 1'b1, 32'h00000000, 1'b1, 1});

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
